sd_req_arbiter: RTL and testbench

- Shares the single block-level SD channel of the HPS I/O bridge between up to 4 virtual-disk requesters (floppy, IDE, etc.).
- Guarantees at most one sd_rd/sd_wr bit is active at any time.
- Sequences each request through the sd_ack handshake, routes the buffer read-data mux, and drops requests that the HPS never acknowledges.
- Sits between the core's disk controllers and the bridge's sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_din ports, all in clk_sys.

---
 rtl/sd_arb_pkg.sv | 33 +++
 rtl/sd_req_arbiter_rr_picker.sv | 20 ++
 rtl/sd_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types, constants and round-robin helper for the SD channel arbiter.
package sd_arb_pkg;

    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned LBA_W   = 32;
    localparam int unsigned TO_W    = 25;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        DONE,
        ERR,
        COOLDOWN
    } arb_state_e;

    // First pending index after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] pending,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] cand;
        rr_next = last;
        for (int k = int'(MAX_REQ); k >= 1; k--) begin
            cand = last + IDX_W'(k);
            if (pending[cand]) begin
                rr_next = cand;
            end
        end
    endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_picker.sv
// Combinational round-robin selector over up to MAX_REQ request bits.
module rr_picker
    import sd_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]     i_pending,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    logic [MAX_REQ-1:0] w_pending_ext;

    // Zero-extend so unused requester slots never win.
    assign w_pending_ext = MAX_REQ'(i_pending);
    assign o_idx_c       = rr_next(w_pending_ext, i_last);
    assign o_valid_c     = |i_pending;

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares the bridge's single SD block channel among NREQ virtual-disk requesters.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 32'd16777216
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [LBA_W*NREQ-1:0] req_lba,
    input  logic [NREQ-1:0]       req_rd,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [DW*NREQ-1:0]    req_buff_din,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       req_err,
    output logic [LBA_W-1:0]      sd_lba,
    output logic [NREQ-1:0]       sd_rd,
    output logic [NREQ-1:0]       sd_wr,
    input  logic                  sd_ack,
    output logic [DW-1:0]         sd_buff_din,
    output logic                  busy,
    output logic [IDX_W-1:0]      grant_idx
);

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_grant;
    logic               r_dir_wr;
    logic               r_busy;
    logic [LBA_W-1:0]   r_lba;
    logic [NREQ-1:0]    r_sd_rd;
    logic [NREQ-1:0]    r_sd_wr;
    logic [NREQ-1:0]    r_done;
    logic [NREQ-1:0]    r_err;
    logic [TO_W-1:0]    r_cnt;

    logic [NREQ-1:0]    w_pending;
    logic [MAX_REQ-1:0] w_pending_ext;
    logic [MAX_REQ-1:0] w_rd_ext;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [LBA_W-1:0]   w_pick_lba;
    logic [NREQ-1:0]    w_grant_oh;
    logic [DW-1:0]      w_buff_mux;
    logic               w_issued;
    logic               w_timeout_hit;
    logic               w_still_pending;

    // Read wins over write when a requester raises both.
    assign w_pending     = req_rd | req_wr;
    assign w_pending_ext = MAX_REQ'(w_pending);
    assign w_rd_ext      = MAX_REQ'(req_rd);

    // The round-robin pointer is simply the last grant.
    rr_picker #(
        .N (NREQ)
    ) u_picker (
        .i_pending (w_pending),
        .i_last    (r_grant),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    // Slice selection for the candidate LBA and the granted requester's data/one-hot.
    always_comb begin
        w_pick_lba = '0;
        w_buff_mux = '0;
        w_grant_oh = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_lba = req_lba[LBA_W*i +: LBA_W];
            end
            if (r_grant == IDX_W'(i)) begin
                w_buff_mux    = req_buff_din[DW*i +: DW];
                w_grant_oh[i] = 1'b1;
            end
        end
    end

    assign w_issued        = |(r_sd_rd | r_sd_wr);
    assign w_still_pending = w_pending_ext[r_grant];
    assign w_timeout_hit   = (TIMEOUT != 0) && (r_cnt == TO_W'(TIMEOUT - 1));

    // Request sequencer: grant, issue, ack handshake, completion/error pulse, cooldown.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_dir_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_lba    <= '0;
            r_sd_rd  <= '0;
            r_sd_wr  <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant  <= w_pick_idx;
                        r_lba    <= w_pick_lba;
                        r_dir_wr <= ~w_rd_ext[w_pick_idx];
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    if (w_issued && sd_ack) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_state <= XFER;
                    end else if (w_issued && w_timeout_hit) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_state <= ERR;
                    end else if (!w_still_pending) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (!w_issued) begin
                        r_sd_rd <= r_dir_wr ? '0 : w_grant_oh;
                        r_sd_wr <= r_dir_wr ? w_grant_oh : '0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= w_grant_oh;
                    r_state <= COOLDOWN;
                end
                ERR: begin
                    r_err   <= w_grant_oh;
                    r_state <= COOLDOWN;
                end
                COOLDOWN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ack     = (sd_ack && r_busy) ? w_grant_oh : '0;
    assign req_done    = r_done;
    assign req_err     = r_err;
    assign sd_lba      = r_lba;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign sd_buff_din = w_buff_mux;
    assign busy        = r_busy;
    assign grant_idx   = r_grant;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: timestamp-based reference model plus directed scenarios.
module tb_sd_req_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int TMO   = 16;
    localparam int NEVER = 32'h4000_0000;

    logic                 clk_sys = 1'b0;
    logic                 reset;
    logic [32*NREQ-1:0]   req_lba;
    logic [NREQ-1:0]      req_rd;
    logic [NREQ-1:0]      req_wr;
    logic [DW*NREQ-1:0]   req_buff_din;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      req_err;
    logic [31:0]          sd_lba;
    logic [NREQ-1:0]      sd_rd;
    logic [NREQ-1:0]      sd_wr;
    logic                 sd_ack;
    logic [DW-1:0]        sd_buff_din;
    logic                 busy;
    logic [1:0]           grant_idx;

    int n_cmp = 0;
    int n_bad = 0;

    int         exp_seq  [6] = '{1, 2, 3, 0, 1, 2};
    logic [7:0] bdin_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_buff_din (req_buff_din),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .req_err      (req_err),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy),
        .grant_idx    (grant_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Reference model: every transaction is described by the edge numbers of its events.
    int          t = 0;
    bit          m_on = 1'b0;
    bit          m_act = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_acked = 1'b0;
    int          m_g = 0;
    logic [31:0] m_lba = '0;
    int          tg = NEVER;
    int          toff = NEVER;
    int          tfall = NEVER;
    int          terr = NEVER;
    int          tend = NEVER;

    always @(posedge clk_sys) begin : ref_model
        logic [NREQ-1:0] pend;
        int              pick;
        bit              still;
        t    = t + 1;
        m_on = 1'b1;
        pend = req_rd | req_wr;
        if (reset) begin
            m_act   = 1'b0;
            m_g     = 0;
            m_wr    = 1'b0;
            m_acked = 1'b0;
            m_lba   = '0;
            tg      = NEVER;
            toff    = NEVER;
            tfall   = NEVER;
            terr    = NEVER;
            tend    = NEVER;
        end else if (!m_act) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (pick < 0 && pend[(m_g + k) % NREQ]) pick = (m_g + k) % NREQ;
            end
            if (pick >= 0) begin
                m_g     = pick;
                m_wr    = !req_rd[pick];
                m_lba   = req_lba[32*pick +: 32];
                m_act   = 1'b1;
                m_acked = 1'b0;
                tg      = t;
                toff    = NEVER;
                tfall   = NEVER;
                terr    = NEVER;
                tend    = NEVER;
            end
        end else begin
            still = pend[m_g];
            if (toff == NEVER) begin
                if (t == tg + 1) begin
                    if (!still) begin
                        toff = t;
                        tend = t;
                    end
                end else if (sd_ack) begin
                    toff    = t;
                    m_acked = 1'b1;
                end else if (TMO > 0 && t == tg + 1 + TMO) begin
                    toff = t;
                    terr = t + 1;
                    tend = t + 2;
                end else if (!still) begin
                    toff = t;
                    tend = t;
                end
            end else if (m_acked && tfall == NEVER && !sd_ack) begin
                tfall = t;
                tend  = t + 2;
            end
            if (t == tend) m_act = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_sys) begin : cmp
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] e_rw;
        logic [NREQ-1:0] e_done;
        logic [NREQ-1:0] e_err;
        logic [NREQ-1:0] e_ack;
        if (m_on) begin
            oh     = NREQ'(1) << m_g;
            e_rw   = (m_act && toff == NEVER && t > tg) ? oh : '0;
            e_done = (tfall != NEVER && t == tfall + 1) ? oh : '0;
            e_err  = (t == terr) ? oh : '0;
            e_ack  = (sd_ack && m_act) ? oh : '0;
            chk("sd_rd", 32'(sd_rd), 32'(m_wr ? '0 : e_rw));
            chk("sd_wr", 32'(sd_wr), 32'(m_wr ? e_rw : '0));
            chk("busy", 32'(busy), 32'(m_act));
            chk("grant_idx", 32'(grant_idx), 32'(m_g));
            chk("sd_lba", sd_lba, m_lba);
            chk("req_done", 32'(req_done), 32'(e_done));
            chk("req_err", 32'(req_err), 32'(e_err));
            chk("req_ack", 32'(req_ack), 32'(e_ack));
            if (m_act) chk("sd_buff_din", 32'(sd_buff_din), 32'(req_buff_din[DW*m_g +: DW]));
        end
    end

    // Wait for an issue, ack it briefly, wait for done; optionally drop the request.
    task automatic serve(input bit drop, output int g);
        int n;
        g = -1;
        for (n = 0; n < 60; n++) begin
            @(negedge clk_sys);
            if ((sd_rd | sd_wr) != '0) break;
        end
        chk("serve_issue_wait", 32'(n < 60 ? 1 : 0), 32'd1);
        if (n >= 60) return;
        g = int'(grant_idx);
        chk("serve_buff_din", 32'(sd_buff_din), 32'(bdin_tab[g]));
        tick(2);
        sd_ack = 1'b1;
        tick(3);
        sd_ack = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge clk_sys);
            if (req_done != '0) break;
        end
        chk("serve_done_wait", 32'(n < 10 ? 1 : 0), 32'd1);
        if (n < 10) chk("serve_done_bit", 32'(req_done), 32'(NREQ'(1) << g));
        if (drop) begin
            req_rd[g] = 1'b0;
            req_wr[g] = 1'b0;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int g;
        int cnt_a;
        int cnt_b;
        reset        = 1'b1;
        req_lba      = '0;
        req_rd       = '0;
        req_wr       = '0;
        sd_ack       = 1'b0;
        req_buff_din = 32'h4433_2211;
        tick(3);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_sd_lba", sd_lba, 32'd0);
        chk("rst_sd_rw", 32'(sd_rd | sd_wr), 32'd0);
        tick(1);

        // Single read on requester 0.
        req_lba[31:0] = 32'h0000_1234;
        req_rd[0]     = 1'b1;
        tick(2);
        chk("single_sd_rd", 32'(sd_rd), 32'h1);
        chk("single_sd_lba", sd_lba, 32'h0000_1234);
        tick(5);
        sd_ack = 1'b1;
        cnt_a  = 0;
        for (int c = 0; c < 512; c++) begin
            @(negedge clk_sys);
            if (req_ack != 4'b0001) cnt_a++;
        end
        chk("single_ack_mirror", 32'(cnt_a), 32'd0);
        tick(1);
        sd_ack = 1'b0;
        tick(1);
        chk("single_done_early", 32'(req_done), 32'd0);
        tick(1);
        chk("single_done", 32'(req_done), 32'h1);
        req_rd[0] = 1'b0;
        tick(1);
        chk("single_done_once", 32'(req_done), 32'd0);
        tick(3);

        // Stray ack while idle.
        sd_ack = 1'b1;
        cnt_a  = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_sys);
            if (req_ack != '0 || req_done != '0 || busy) cnt_a++;
        end
        tick(1);
        sd_ack = 1'b0;
        chk("stray_ack", 32'(cnt_a), 32'd0);
        tick(2);

        // Read and write raised together on one requester: read only.
        req_rd[0] = 1'b1;
        req_wr[0] = 1'b1;
        tick(2);
        chk("conflict_sd_rd", 32'(sd_rd), 32'h1);
        chk("conflict_sd_wr", 32'(sd_wr), 32'd0);
        serve(1'b1, g);
        chk("conflict_grant", 32'(g), 32'd0);
        tick(3);

        // Timeout on requester 1 write.
        req_lba[63:32] = 32'h0000_BEEF;
        req_wr[1]      = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_sys);
            if (sd_wr == 4'b0010) cnt_a++;
            if (req_err == 4'b0010) begin
                cnt_b++;
                req_wr[1] = 1'b0;
            end
        end
        chk("timeout_wr_cycles", 32'(cnt_a), 32'd16);
        chk("timeout_err_pulses", 32'(cnt_b), 32'd1);
        chk("timeout_idle", 32'(busy), 32'd0);
        tick(1);

        // Contention: requester 0 read and requester 1 write, pointer at 1.
        req_rd[0] = 1'b1;
        req_wr[1] = 1'b1;
        serve(1'b1, g);
        chk("contend_first", 32'(g), 32'd0);
        serve(1'b1, g);
        chk("contend_second", 32'(g), 32'd1);
        tick(3);

        // Fairness from a fresh pointer with every requester held.
        reset = 1'b1;
        tick(2);
        reset  = 1'b0;
        req_rd = 4'hF;
        for (int i = 0; i < 6; i++) begin
            serve(1'b0, g);
            chk("fair_seq", 32'(g), 32'(exp_seq[i]));
        end
        req_rd = '0;
        tick(4);

        // Reset in the middle of a transfer, then normal re-grant.
        req_rd[3] = 1'b1;
        for (cnt_a = 0; cnt_a < 60; cnt_a++) begin
            @(negedge clk_sys);
            if (sd_rd != '0) break;
        end
        chk("rst_xfer_issue", 32'(sd_rd), 32'h8);
        tick(1);
        sd_ack = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rst_xfer_busy", 32'(busy), 32'd0);
        chk("rst_xfer_ack", 32'(req_ack), 32'd0);
        chk("rst_xfer_rw", 32'(sd_rd | sd_wr), 32'd0);
        chk("rst_xfer_lba", sd_lba, 32'd0);
        chk("rst_xfer_grant", 32'(grant_idx), 32'd0);
        reset  = 1'b0;
        sd_ack = 1'b0;
        serve(1'b1, g);
        chk("rst_regrant", 32'(g), 32'd3);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
